// File: rtl/alarm_frame_pkg.sv
// rtl/alarm_frame_pkg.sv - shared widths, states and frame type for the alarm frame receiver
package alarm_frame_pkg;

  localparam int         SYNC_W_DEF   = 4;
  localparam logic [3:0] SYNC_PAT_DEF = 4'b1010;
  localparam int         ID_W_DEF     = 8;
  localparam int         ZONE_W_DEF   = 4;
  localparam int         EVT_W_DEF    = 4;
  localparam int         TIMEOUT_DEF  = 64;

  // Payload is everything after the preamble: ID, zone, event and the parity bit
  localparam int PAYLOAD_W = ID_W_DEF + ZONE_W_DEF + EVT_W_DEF + 1;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } rx_state_t;

  // Decoded frame as consumed by the alarm control FSM
  typedef struct packed {
    logic [ID_W_DEF-1:0]   id;
    logic [ZONE_W_DEF-1:0] zone;
    logic [EVT_W_DEF-1:0]  evt;
  } alarm_frame_t;

endpackage

// File: rtl/alarm_sync_detect.sv
// rtl/alarm_sync_detect.sv - sliding-window preamble detector with synchronous clear
module alarm_sync_detect #(
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1010
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);

  logic [SYNC_W-1:0] window;
  logic [SYNC_W-1:0] window_shifted;

  // Candidate window including the bit on the wire this cycle
  always_comb begin
    window_shifted = {window[SYNC_W-2:0], bit_in};
    match          = shift_en && (window_shifted == SYNC_PAT);
  end

  // Window history; clear wins so a finished frame never seeds the next hunt
  always_ff @(posedge CLK) begin
    if (!reset || clear) begin
      window <= '0;
    end else if (shift_en) begin
      window <= window_shifted;
    end
  end

endmodule

// File: rtl/alarm_frame_receiver.sv
// rtl/alarm_frame_receiver.sv - serial alarm frame hunter/deserializer; ALARM_FRAME_ERRCNT_EN adds ERR_COUNT
module alarm_frame_receiver
  import alarm_frame_pkg::*;
#(
  parameter int                SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
  parameter int                ID_W     = ID_W_DEF,
  parameter int                ZONE_W   = ZONE_W_DEF,
  parameter int                EVT_W    = EVT_W_DEF,
  parameter int                TIMEOUT  = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              BIT_IN,
  input  logic              BIT_VALID,
  output logic [ID_W-1:0]   SENSOR_ID,
  output logic [ZONE_W-1:0] ZONE,
  output logic [EVT_W-1:0]  EVENT,
  output logic              FRAME_VALID,
  output logic              PARITY_ERR,
`ifdef ALARM_FRAME_ERRCNT_EN
  output logic [7:0]        ERR_COUNT,
`endif
  output logic              FRAME_ABORT
);

  localparam int PL_W  = ID_W + ZONE_W + EVT_W + 1;
  localparam int CNT_W = $clog2(PL_W + 1);

  rx_state_t        state;
  rx_state_t        state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [PL_W-2:0]  payload_sr;
  logic [PL_W-1:0]  payload_next;
  logic             parity_acc;
  logic [7:0]       idle_cnt;

  logic             sync_match;
  logic             hunt_shift;
  logic             last_bit;
  logic             timeout_hit;
  logic             frame_good;
  logic             frame_bad;

  alarm_sync_detect #(
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (SYNC_PAT)
  ) u_sync (
    .CLK      (CLK),
    .reset    (reset),
    .clear    (last_bit || timeout_hit),
    .shift_en (hunt_shift),
    .bit_in   (BIT_IN),
    .match    (sync_match)
  );

  // Full payload as it stands once this cycle's bit is included
  always_comb begin
    payload_next = {payload_sr, BIT_IN};
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: lock on preamble, leave on last payload bit or idle expiry
  always_comb begin
    state_next = state;
    case (state)
      HUNT:    if (sync_match) state_next = COLLECT;
      COLLECT: if (last_bit || timeout_hit) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  // Control strobes; an arriving bit always beats an expiring idle counter
  always_comb begin
    hunt_shift  = 1'b0;
    last_bit    = 1'b0;
    timeout_hit = 1'b0;
    frame_good  = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      HUNT: hunt_shift = BIT_VALID;
      COLLECT: begin
        last_bit    = BIT_VALID && (bit_cnt == CNT_W'(PL_W - 1));
        timeout_hit = !BIT_VALID && (idle_cnt == 8'(TIMEOUT - 1));
        frame_good  = last_bit && !(parity_acc ^ BIT_IN);
        frame_bad   = last_bit && (parity_acc ^ BIT_IN);
      end
      default: ;
    endcase
  end

  // Payload shift, running parity and idle counting while collecting
  always_ff @(posedge CLK) begin
    if (!reset) begin
      bit_cnt    <= '0;
      payload_sr <= '0;
      parity_acc <= 1'b0;
      idle_cnt   <= '0;
    end else if (state == HUNT) begin
      bit_cnt    <= '0;
      parity_acc <= 1'b0;
      idle_cnt   <= '0;
    end else if (BIT_VALID) begin
      payload_sr <= payload_next[PL_W-2:0];
      parity_acc <= parity_acc ^ BIT_IN;
      bit_cnt    <= bit_cnt + 1'b1;
      idle_cnt   <= '0;
    end else begin
      idle_cnt   <= idle_cnt + 1'b1;
    end
  end

  // Registered result pulses; fields only move on a good frame
  always_ff @(posedge CLK) begin
    if (!reset) begin
      SENSOR_ID   <= '0;
      ZONE        <= '0;
      EVENT       <= '0;
      FRAME_VALID <= 1'b0;
      PARITY_ERR  <= 1'b0;
      FRAME_ABORT <= 1'b0;
    end else begin
      FRAME_VALID <= frame_good;
      PARITY_ERR  <= frame_bad;
      FRAME_ABORT <= timeout_hit;
      if (frame_good) begin
        SENSOR_ID <= payload_next[PL_W-1:PL_W-ID_W];
        ZONE      <= payload_next[EVT_W+ZONE_W:EVT_W+1];
        EVENT     <= payload_next[EVT_W:1];
      end
    end
  end

`ifdef ALARM_FRAME_ERRCNT_EN
  // Saturating count of dropped frames, cleared only by reset
  always_ff @(posedge CLK) begin
    if (!reset) begin
      ERR_COUNT <= '0;
    end else if ((frame_bad || timeout_hit) && (ERR_COUNT != 8'hFF)) begin
      ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end
`endif

endmodule

// File: doc/alarm_frame_receiver.md
Name: alarm_frame_receiver

Overview:
Downstream consumer of the 21-bit delay shift register in the alarm controller. Receives its serial BIT_OUT stream and hunts for a sync preamble. Deserializes the following sensor ID / zone / event fields and checks even parity. Presents each good frame as a parallel word with a one-cycle valid pulse to the alarm control FSM.

Parameters:
SYNC_W, 4, preamble width in bits
SYNC_PAT, 4'b1010, preamble pattern; must be nonzero
ID_W, 8, sensor ID field width
ZONE_W, 4, zone field width
EVT_W, 4, event code field width
TIMEOUT, 64, max idle cycles (BIT_VALID low) tolerated inside a frame; range 1..255

Ports:
CLK  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset (low = reset)
BIT_IN  in  1  serial data, driven by shift register BIT_OUT
BIT_VALID  in  1  BIT_IN sampled only when high; tie high for one bit per CLK
SENSOR_ID  out  ID_W  last good frame ID
ZONE  out  ZONE_W  last good frame zone
EVENT  out  EVT_W  last good frame event
FRAME_VALID  out  1  one-cycle pulse, new good frame on outputs
PARITY_ERR  out  1  one-cycle pulse, frame dropped on parity
FRAME_ABORT  out  1  one-cycle pulse, frame dropped on timeout

Behaviour:
- Frame, first received bit first: SYNC_PAT (SYNC_W bits), ID, ZONE, EVT, parity bit. Default total is 21 bits. Within each field, the first bit received is the MSB.
- Parity is even: XOR of all payload bits and the parity bit must be 0. The sync bits are excluded.
- Reset (reset==0 at a CLK edge): state=HUNT, sync window=0, bit count=0, idle count=0, all outputs 0. Reset mid-frame discards the partial frame with no pulse.
- HUNT: on each BIT_VALID, window <= {window[SYNC_W-2:0], BIT_IN}. If the shifted window equals SYNC_PAT, go to COLLECT with count=0 and parity accumulator=0. Detection is sliding, so overlapping or false prefixes are handled.
- COLLECT: each BIT_VALID shifts BIT_IN into the payload register, XORs it into the accumulator and increments count.
  - The payload is ID_W+ZONE_W+EVT_W+1 bits long.
  - On the bit that completes the payload, evaluate parity in the same cycle and go to HUNT with window cleared to 0.
  - If parity is good, register the fields and pulse FRAME_VALID on the next cycle. Latency is 1 cycle after the parity bit is sampled.
  - If parity is bad, pulse PARITY_ERR. The field outputs keep their previous values.
- Back-to-back frames: the next sync may start on the very next BIT_VALID after the parity bit; no bit is lost.
- Idle timeout: in COLLECT, the idle counter increments on each cycle with BIT_VALID low and clears on each BIT_VALID.
  - When the counter reaches TIMEOUT, go to HUNT, clear the window and pulse FRAME_ABORT.
  - If BIT_VALID is high in the same cycle the counter would expire, the bit wins: it is accepted and the counter clears.
- The idle counter is inactive in HUNT.
- FRAME_VALID, PARITY_ERR and FRAME_ABORT are mutually exclusive and never asserted for two consecutive cycles from the same frame.
- Data outputs hold their values until the next good frame.

Optional Feature:
Macro ALARM_FRAME_ERRCNT_EN.
- Defined: adds output ERR_COUNT, 8 bits. It increments on every PARITY_ERR or FRAME_ABORT pulse, saturates at 255 and clears only on reset.
- Undefined: the port and its logic are absent; everything else is identical.

Decomposition:
- Shared package alarm_frame_pkg holds:
  - field width constants and SYNC_PAT default;
  - derived PAYLOAD_W;
  - state enum {HUNT, COLLECT};
  - a frame struct typedef (id, zone, evt) for reuse by the alarm control FSM.
- Natural sub-module: alarm_sync_detect, containing the sliding window compare with a clear input and a match output.

Test Plan:
- Continuous BIT_VALID=1, bits 1010 + A5 + 3 + 9 + parity 0 starting cycle 0 -> FRAME_VALID at cycle 21 with SENSOR_ID=8'hA5, ZONE=4'h3, EVENT=4'h9; no error pulses.
- Same frame with parity bit 1 -> PARITY_ERR at cycle 21, FRAME_VALID stays 0, outputs keep prior values. With the macro defined, ERR_COUNT goes 0->1.
- Prefix 1,0,1,1,0,1,0 then a valid payload -> sync locks on the final 1010 and the frame decodes correctly. Noise containing no 1010 -> no pulses.
- Valid sync + 10 payload bits, then BIT_VALID=0 for 64 cycles -> FRAME_ABORT on the 64th idle cycle. Repeating with BIT_VALID high on cycle 64 -> no abort and the frame continues.
- Two good frames back-to-back with no gap (42 bits) -> two FRAME_VALID pulses 21 cycles apart, the second carrying the second frame's fields.
- reset low for 1 cycle at bit 12 of a frame, then a full valid frame -> no pulse for the first frame, all outputs 0 after reset, and the second frame decodes correctly.
